fft_ctrl_seq: RTL and testbench
===============================

# fft_ctrl_seq

Butterfly-schedule sequencer for the radix-2 DIT FFT unit.
- Consumes the one-cycle start pulse produced by the start edge detector.
- Issues, one per cycle, the read-address pair, twiddle index and stage number for every butterfly of an N-point transform.
- Replays each butterfly's address pair as a write-back strobe after the fixed butterfly pipeline latency.
- Inserts drain gaps so a stage never reads data its predecessor has not yet written, then reports completion.

## Interface
- N_POINT, 8, transform size; power of two, ≥4.
- BF_LATENCY, 2, cycles from butterfly read issue to its write-back; ≥1.
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  start pulse, one cycle; honoured only in IDLE.
- o_busy  out  1  high from first issue cycle through last write-back cycle.
- o_done  out  1  one-cycle completion pulse.
- o_rd_en  out  1  butterfly issue strobe.
- o_rd_addr_a / o_rd_addr_b  out  AW each  butterfly operand addresses; AW = $clog2(N_POINT).
- o_tw_idx  out  AW-1  twiddle index into a W_N^k table, k < N/2.
- o_stage  out  SW  current stage; SW = max(1, $clog2(AW)).
- o_wr_en  out  1  write-back strobe.
- o_wr_addr_a / o_wr_addr_b  out  AW each  write-back addresses.

## Operation
- States: IDLE, ISSUE, GAP, DONE.
- IDLE → ISSUE when i_start=1.
- ISSUE issues butterflies b = 0..N/2-1 of stage s, one per cycle. After b = N/2-1 → GAP.
- GAP holds o_rd_en=0 for exactly BF_LATENCY cycles. Then:
  - s < AW-1 → ISSUE with s+1, b=0;
  - otherwise → DONE.
- DONE lasts one cycle with o_done=1, then → IDLE.
- i_start outside IDLE is ignored; it is neither queued nor counted.
- Address generation per butterfly, all unsigned and truncated to AW bits:
  - half = 1<<s;
  - a = ((b>>s)<<(s+1)) | (b & (half-1));
  - bb = a + half;
  - tw = (b & (half-1)) << (AW-1-s).
- Write-back delay line: a BF_LATENCY-deep shift of {rd_en, addr_a, addr_b} drives {o_wr_en, o_wr_addr_a, o_wr_addr_b}.
- All outputs are registered.
- Reset, including mid-run:
  - state → IDLE; s, b and gap counters → 0;
  - every delay-line stage cleared, so no write-back strobe issued before reset appears after it;
  - every output reads 0 in the cycle after i_rst is sampled high.
- Reset value of every output: 0.

## Timing
Example: N_POINT=8, BF_LATENCY=2, i_start sampled high in cycle 0.
- Stage 0:
  - issue cycles 1-4: (a,b) = (0,1)(2,3)(4,5)(6,7), tw=0;
  - writes cycles 3-6.
- Gap: cycles 5-6.
- Stage 1:
  - issue cycles 7-10: (0,2)(1,3)(4,6)(5,7), tw = 0,2,0,2;
  - writes cycles 9-12.
- Gap: cycles 11-12.
- Stage 2:
  - issue cycles 13-16: (0,4)(1,5)(2,6)(3,7), tw = 0,1,2,3;
  - writes cycles 15-18.
- o_busy high cycles 1-18; o_done high cycle 19; IDLE in cycle 20.
- General:
  - first issue 1 cycle after start;
  - o_done at cycle AW·(N/2 + BF_LATENCY) + 1;
  - o_busy is low in the o_done cycle.
- Each write-back occurs exactly BF_LATENCY cycles after its issue, carrying the same addresses.
- Next-stage first read is one cycle after the previous stage's last write, so there is no read-after-write overlap.
- i_start in the cycle after o_done (state IDLE) begins a new run with identical timing.

## Structure
- Shared package fft_pkg holds:
  - the state enum (IDLE, ISSUE, GAP, DONE);
  - localparam helpers for AW, SW and the N/2 butterfly count.
- One sub-module: fft_addr_delay, a parameterised depth-BF_LATENCY shift register for {en, addr_a, addr_b}.
  - Synchronous active-high clear.
  - The parent instantiates it once.
- Parent holds the FSM, stage/butterfly/gap counters and address arithmetic.

## Test plan
- Nominal run (N=8, L=2), start at cycle 0:
  - rd addresses, tw and stage match the Timing example each cycle;
  - wr_en cycles 3-6, 9-12, 15-18 with matching addresses;
  - o_done only at cycle 19.
- Start while busy: pulses at cycles 5 and 12 → schedule identical to the nominal run; exactly one o_done.
- Reset mid-run:
  - i_rst high in cycle 8 → all outputs 0 from cycle 9;
  - no o_wr_en afterwards;
  - a later i_start produces the full nominal schedule.
- Back-to-back: start at cycle 0 and again at cycle 20 → second o_done at cycle 39; o_busy low only in cycles 19-20.
- Parameter L=1 (N=8): gaps 1 cycle, first-stage writes in cycles 2-5; o_done at cycle 16.
- N=16, L=2: 4 stages of 8 butterflies; stage 3 pairs (k, k+8), tw=k; o_done at cycle 41.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and width helpers for the radix-2 DIT FFT butterfly sequencer.
package fft_pkg;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } fft_state_t;

    // Address width for an n-point transform.
    function automatic int unsigned fn_aw(input int unsigned n);
        return $clog2(n);
    endfunction

    // Stage-number width: enough for 0..AW-1, never narrower than one bit.
    function automatic int unsigned fn_sw(input int unsigned n);
        int unsigned w;
        w = $clog2($clog2(n));
        return (w > 1) ? w : 1;
    endfunction

    // Butterflies per stage.
    function automatic int unsigned fn_nbf(input int unsigned n);
        return n / 2;
    endfunction

    // Counter width able to hold 0..x-1, never narrower than one bit.
    function automatic int unsigned fn_cnt_w(input int unsigned x);
        int unsigned w;
        w = $clog2(x);
        return (w > 1) ? w : 1;
    endfunction

endpackage

// File: rtl/fft_addr_delay.sv
// Fixed-depth shift register replaying issued butterfly address pairs as write-back strobes.
module fft_addr_delay #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = 3
) (
    input  logic          i_clk,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [AW-1:0] i_addr_a,
    input  logic [AW-1:0] i_addr_b,
    output logic          o_en,
    output logic [AW-1:0] o_addr_a,
    output logic [AW-1:0] o_addr_b
);

    logic          r_en     [DEPTH];
    logic [AW-1:0] r_addr_a [DEPTH];
    logic [AW-1:0] r_addr_b [DEPTH];

    // Shift one stage per cycle; clear wipes every stage so nothing in flight survives.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_en[i]     <= 1'b0;
                r_addr_a[i] <= '0;
                r_addr_b[i] <= '0;
            end
        end else begin
            r_en[0]     <= i_en;
            r_addr_a[0] <= i_addr_a;
            r_addr_b[0] <= i_addr_b;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_en[i]     <= r_en[i-1];
                r_addr_a[i] <= r_addr_a[i-1];
                r_addr_b[i] <= r_addr_b[i-1];
            end
        end
    end

    assign o_en     = r_en[DEPTH-1];
    assign o_addr_a = r_addr_a[DEPTH-1];
    assign o_addr_b = r_addr_b[DEPTH-1];

endmodule

// File: rtl/fft_ctrl_seq.sv
// Butterfly-schedule sequencer: issues every butterfly of an N-point radix-2 DIT FFT,
// replays its address pair as a write-back after the pipeline latency, and drains between stages.
module fft_ctrl_seq
    import fft_pkg::*;
#(
    parameter  int unsigned N_POINT    = 8,
    parameter  int unsigned BF_LATENCY = 2,
    localparam int unsigned AW         = fn_aw(N_POINT),
    localparam int unsigned SW         = fn_sw(N_POINT),
    localparam int unsigned BW         = AW - 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_rd_en,
    output logic [AW-1:0] o_rd_addr_a,
    output logic [AW-1:0] o_rd_addr_b,
    output logic [BW-1:0] o_tw_idx,
    output logic [SW-1:0] o_stage,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr_a,
    output logic [AW-1:0] o_wr_addr_b
);

    localparam int unsigned NBF = fn_nbf(N_POINT);
    localparam int unsigned GW  = fn_cnt_w(BF_LATENCY);

    fft_state_t    r_state;
    fft_state_t    w_state_nxt;
    logic [SW-1:0] r_stage;
    logic [SW-1:0] w_stage_nxt;
    logic [BW-1:0] r_bf;
    logic [BW-1:0] w_bf_nxt;
    logic [GW-1:0] r_gap;
    logic [GW-1:0] w_gap_nxt;

    logic          w_issue;
    logic          w_busy;
    logic          w_done;

    logic [AW-1:0] w_bf_ext;
    logic [AW-1:0] w_half;
    logic [AW-1:0] w_mask;
    logic [AW-1:0] w_a;
    logic [AW-1:0] w_b;
    logic [SW-1:0] w_tw_sh;
    logic [BW-1:0] w_tw;

    logic          r_busy;
    logic          r_done;
    logic          r_rd_en;
    logic [AW-1:0] r_rd_addr_a;
    logic [AW-1:0] r_rd_addr_b;
    logic [BW-1:0] r_tw_idx;
    logic [SW-1:0] r_stage_out;

    // State and schedule counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_stage <= '0;
            r_bf    <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_stage <= w_stage_nxt;
            r_bf    <= w_bf_nxt;
            r_gap   <= w_gap_nxt;
        end
    end

    // Next-state and counter update; a stage ends after its last butterfly plus a full drain gap.
    always_comb begin
        w_state_nxt = r_state;
        w_stage_nxt = r_stage;
        w_bf_nxt    = r_bf;
        w_gap_nxt   = r_gap;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = ISSUE;
                    w_stage_nxt = '0;
                    w_bf_nxt    = '0;
                end
            end
            ISSUE: begin
                if (r_bf == BW'(NBF - 1)) begin
                    w_state_nxt = GAP;
                    w_gap_nxt   = '0;
                end else begin
                    w_bf_nxt = r_bf + BW'(1);
                end
            end
            GAP: begin
                if (r_gap == GW'(BF_LATENCY - 1)) begin
                    if (r_stage == SW'(AW - 1)) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = ISSUE;
                        w_stage_nxt = r_stage + SW'(1);
                        w_bf_nxt    = '0;
                    end
                end else begin
                    w_gap_nxt = r_gap + GW'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output decode from the next state so registered outputs line up with the state they describe.
    always_comb begin
        w_issue = (w_state_nxt == ISSUE);
        w_busy  = (w_state_nxt == ISSUE) || (w_state_nxt == GAP);
        w_done  = (w_state_nxt == DONE);
    end

    // Butterfly operand pair and twiddle index for the butterfly about to be issued.
    always_comb begin
        w_bf_ext = AW'(w_bf_nxt);
        w_half   = AW'(1) << w_stage_nxt;
        w_mask   = w_half - AW'(1);
        w_a      = (((w_bf_ext >> w_stage_nxt) << 1) << w_stage_nxt) | (w_bf_ext & w_mask);
        w_b      = w_a + w_half;
        w_tw_sh  = SW'(AW - 1) - w_stage_nxt;
        w_tw     = (w_bf_nxt & BW'(w_mask)) << w_tw_sh;
    end

    // Registered issue-side outputs; address fields read zero outside issue cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr_a <= '0;
            r_rd_addr_b <= '0;
            r_tw_idx    <= '0;
            r_stage_out <= '0;
        end else begin
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_rd_en     <= w_issue;
            r_rd_addr_a <= w_issue ? w_a : '0;
            r_rd_addr_b <= w_issue ? w_b : '0;
            r_tw_idx    <= w_issue ? w_tw : '0;
            r_stage_out <= w_busy ? w_stage_nxt : '0;
        end
    end

    // Write-back replay of each issued pair, BF_LATENCY cycles later.
    fft_addr_delay #(
        .DEPTH (BF_LATENCY),
        .AW    (AW)
    ) u_wb_delay (
        .i_clk    (i_clk),
        .i_clr    (i_rst),
        .i_en     (r_rd_en),
        .i_addr_a (r_rd_addr_a),
        .i_addr_b (r_rd_addr_b),
        .o_en     (o_wr_en),
        .o_addr_a (o_wr_addr_a),
        .o_addr_b (o_wr_addr_b)
    );

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_rd_en     = r_rd_en;
    assign o_rd_addr_a = r_rd_addr_a;
    assign o_rd_addr_b = r_rd_addr_b;
    assign o_tw_idx    = r_tw_idx;
    assign o_stage     = r_stage_out;

endmodule

// File: tb/tb_fft_ctrl_seq.sv
// Scoreboard bench for fft_ctrl_seq: three configurations (N=8/L=2, N=8/L=1, N=16/L=2), exercised one at a time.
module tb_fft_ctrl_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0] rst;
    logic [2:0] start;

    // instance 0: N=8, L=2
    logic       busy0, done0, rd_en0, wr_en0;
    logic [2:0] rd_a0, rd_b0, wr_a0, wr_b0;
    logic [1:0] tw0, st0;
    // instance 1: N=8, L=1
    logic       busy1, done1, rd_en1, wr_en1;
    logic [2:0] rd_a1, rd_b1, wr_a1, wr_b1;
    logic [1:0] tw1, st1;
    // instance 2: N=16, L=2
    logic       busy2, done2, rd_en2, wr_en2;
    logic [3:0] rd_a2, rd_b2, wr_a2, wr_b2;
    logic [2:0] tw2;
    logic [1:0] st2;

    fft_ctrl_seq #(.N_POINT(8), .BF_LATENCY(2)) u_dut0 (
        .i_clk(clk), .i_rst(rst[0]), .i_start(start[0]), .o_busy(busy0), .o_done(done0),
        .o_rd_en(rd_en0), .o_rd_addr_a(rd_a0), .o_rd_addr_b(rd_b0), .o_tw_idx(tw0), .o_stage(st0),
        .o_wr_en(wr_en0), .o_wr_addr_a(wr_a0), .o_wr_addr_b(wr_b0));

    fft_ctrl_seq #(.N_POINT(8), .BF_LATENCY(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst[1]), .i_start(start[1]), .o_busy(busy1), .o_done(done1),
        .o_rd_en(rd_en1), .o_rd_addr_a(rd_a1), .o_rd_addr_b(rd_b1), .o_tw_idx(tw1), .o_stage(st1),
        .o_wr_en(wr_en1), .o_wr_addr_a(wr_a1), .o_wr_addr_b(wr_b1));

    fft_ctrl_seq #(.N_POINT(16), .BF_LATENCY(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst[2]), .i_start(start[2]), .o_busy(busy2), .o_done(done2),
        .o_rd_en(rd_en2), .o_rd_addr_a(rd_a2), .o_rd_addr_b(rd_b2), .o_tw_idx(tw2), .o_stage(st2),
        .o_wr_en(wr_en2), .o_wr_addr_a(wr_a2), .o_wr_addr_b(wr_b2));

    // Uniform views of the three instances for the monitor.
    logic [2:0] m_busy, m_done, m_rd_en, m_wr_en;
    logic [7:0] m_rd_a [3];
    logic [7:0] m_rd_b [3];
    logic [7:0] m_tw   [3];
    logic [7:0] m_st   [3];
    logic [7:0] m_wr_a [3];
    logic [7:0] m_wr_b [3];

    assign m_busy  = {busy2, busy1, busy0};
    assign m_done  = {done2, done1, done0};
    assign m_rd_en = {rd_en2, rd_en1, rd_en0};
    assign m_wr_en = {wr_en2, wr_en1, wr_en0};
    assign m_rd_a[0] = 8'(rd_a0); assign m_rd_a[1] = 8'(rd_a1); assign m_rd_a[2] = 8'(rd_a2);
    assign m_rd_b[0] = 8'(rd_b0); assign m_rd_b[1] = 8'(rd_b1); assign m_rd_b[2] = 8'(rd_b2);
    assign m_tw[0]   = 8'(tw0);   assign m_tw[1]   = 8'(tw1);   assign m_tw[2]   = 8'(tw2);
    assign m_st[0]   = 8'(st0);   assign m_st[1]   = 8'(st1);   assign m_st[2]   = 8'(st2);
    assign m_wr_a[0] = 8'(wr_a0); assign m_wr_a[1] = 8'(wr_a1); assign m_wr_a[2] = 8'(wr_a2);
    assign m_wr_b[0] = 8'(wr_b0); assign m_wr_b[1] = 8'(wr_b1); assign m_wr_b[2] = 8'(wr_b2);

    typedef struct {
        int inst;
        int cyc;
        int a;
        int b;
        int tw;
        int st;
    } ev_t;

    ev_t q_rd[$];
    ev_t q_wr[$];
    ev_t q_done[$];
    ev_t q_busy[$];

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_on   = 1'b0;

    // Hand-computed N=8 schedule in issue order: {a, b, tw} for stages 0, 1, 2.
    int tbl8 [36] = '{0,1,0,  2,3,0,  4,5,0,  6,7,0,
                      0,2,0,  1,3,2,  4,6,0,  5,7,2,
                      0,4,0,  1,5,1,  2,6,2,  3,7,3};

    task automatic chk(input string name, input bit ok, input string detail);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    // Compare one observed event against the popped expectation (mode 0: when, 1: +a/b, 2: +tw/stage).
    task automatic cmp_ev(input string nm, input bit have, input ev_t e, input int i,
                          input int a, input int b, input int tw, input int st, input int mode);
        bit ok;
        if (!have) begin
            chk(nm, 1'b0, $sformatf("unexpected event inst=%0d cyc=%0d a=%0d b=%0d", i, cyc, a, b));
        end else begin
            ok = (e.inst == i) && (e.cyc == cyc);
            if (mode >= 1) ok = ok && (e.a == a) && (e.b == b);
            if (mode >= 2) ok = ok && (e.tw == tw) && (e.st == st);
            chk(nm, ok, $sformatf("got inst=%0d cyc=%0d a=%0d b=%0d tw=%0d st=%0d, want inst=%0d cyc=%0d a=%0d b=%0d tw=%0d st=%0d",
                                  i, cyc, a, b, tw, st, e.inst, e.cyc, e.a, e.b, e.tw, e.st));
        end
    endtask

    // Queue the expected schedule of one run started in cycle t0; events after cycle 'cut' are suppressed (reset).
    task automatic push_run(input int inst, input int n, input int lat, input int t0, input int cut);
        int  aw, nb, c, k, tdone;
        ev_t e;
        aw = $clog2(n);
        nb = n / 2;
        for (int s = 0; s < aw; s++) begin
            int half;
            half = 1 << s;
            for (int g = 0; g < n / (2 * half); g++) begin
                for (int j = 0; j < half; j++) begin
                    k = g * half + j;
                    c = t0 + 1 + s * (nb + lat) + k;
                    e.inst = inst; e.st = s;
                    if (n == 8) begin
                        e.a  = tbl8[(s * 4 + k) * 3];
                        e.b  = tbl8[(s * 4 + k) * 3 + 1];
                        e.tw = tbl8[(s * 4 + k) * 3 + 2];
                    end else begin
                        e.a  = g * 2 * half + j;
                        e.b  = e.a + half;
                        e.tw = j * (n / (2 * half));
                    end
                    e.cyc = c;
                    if (c <= cut) q_rd.push_back(e);
                    e.cyc = c + lat;
                    if (c + lat <= cut) q_wr.push_back(e);
                end
            end
        end
        tdone = t0 + aw * (nb + lat) + 1;
        e = '{inst: inst, cyc: t0 + 1, a: 1, b: 0, tw: 0, st: 0};
        q_busy.push_back(e);
        e.a = 0;
        if (tdone <= cut) begin
            e.cyc = tdone;
            q_done.push_back(e);
            q_busy.push_back(e);
        end else begin
            e.cyc = cut + 1;
            q_busy.push_back(e);
        end
    endtask

    task automatic check_zero(input string nm, input int i);
        bit ok;
        ok = !m_busy[i] && !m_done[i] && !m_rd_en[i] && !m_wr_en[i] &&
             m_rd_a[i] == 0 && m_rd_b[i] == 0 && m_tw[i] == 0 && m_st[i] == 0 &&
             m_wr_a[i] == 0 && m_wr_b[i] == 0;
        chk(nm, ok, $sformatf("inst=%0d got busy=%0b done=%0b rd_en=%0b wr_en=%0b rd=%0d/%0d tw=%0d st=%0d wr=%0d/%0d, want all 0",
                              i, m_busy[i], m_done[i], m_rd_en[i], m_wr_en[i], m_rd_a[i], m_rd_b[i],
                              m_tw[i], m_st[i], m_wr_a[i], m_wr_b[i]));
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) next();
    endtask

    task automatic pulse(input int i);
        start[i] = 1'b1;
        next();
        start[i] = 1'b0;
    endtask

    // Monitor: pop and compare whenever any instance presents an event.
    logic [2:0] prev_busy = 3'b000;
    always @(negedge clk) begin
        ev_t e;
        bit  have;
        if (mon_on) begin
            for (int i = 0; i < 3; i++) begin
                if (m_rd_en[i]) begin
                    have = (q_rd.size() > 0);
                    if (have) e = q_rd.pop_front();
                    cmp_ev("rd", have, e, i, int'(m_rd_a[i]), int'(m_rd_b[i]), int'(m_tw[i]), int'(m_st[i]), 2);
                end
                if (m_wr_en[i]) begin
                    have = (q_wr.size() > 0);
                    if (have) e = q_wr.pop_front();
                    cmp_ev("wr", have, e, i, int'(m_wr_a[i]), int'(m_wr_b[i]), 0, 0, 1);
                end
                if (m_done[i]) begin
                    have = (q_done.size() > 0);
                    if (have) e = q_done.pop_front();
                    cmp_ev("done", have, e, i, 0, 0, 0, 0, 0);
                end
                if (m_busy[i] != prev_busy[i]) begin
                    have = (q_busy.size() > 0);
                    if (have) e = q_busy.pop_front();
                    cmp_ev("busy_edge", have, e, i, int'(m_busy[i]), 0, 0, 0, 1);
                end
            end
            prev_busy <= m_busy;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: no finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst   = 3'b111;
        start = 3'b000;
        repeat (3) next();
        check_zero("reset_state0", 0);
        check_zero("reset_state1", 1);
        check_zero("reset_state2", 2);
        rst = 3'b000;
        next();
        mon_on = 1'b1;

        // Nominal run, N=8 L=2.
        next();
        t0 = cyc;
        push_run(0, 8, 2, t0, 1 << 30);
        pulse(0);
        goto(t0 + 22);

        // Start pulses while busy are ignored.
        t0 = cyc;
        push_run(0, 8, 2, t0, 1 << 30);
        pulse(0);
        goto(t0 + 5);
        pulse(0);
        goto(t0 + 12);
        pulse(0);
        goto(t0 + 22);

        // Reset mid-run in cycle 8, then a fresh run.
        t0 = cyc;
        push_run(0, 8, 2, t0, t0 + 8);
        pulse(0);
        goto(t0 + 8);
        rst[0] = 1'b1;
        next();
        rst[0] = 1'b0;
        check_zero("reset_mid", 0);
        goto(t0 + 16);
        t0 = cyc;
        push_run(0, 8, 2, t0, 1 << 30);
        pulse(0);
        goto(t0 + 22);

        // Back-to-back runs: second start in the cycle after o_done.
        t0 = cyc;
        push_run(0, 8, 2, t0, 1 << 30);
        push_run(0, 8, 2, t0 + 20, 1 << 30);
        pulse(0);
        goto(t0 + 20);
        pulse(0);
        goto(t0 + 42);

        // N=8, L=1.
        t0 = cyc;
        push_run(1, 8, 1, t0, 1 << 30);
        pulse(1);
        goto(t0 + 20);

        // N=16, L=2.
        t0 = cyc;
        push_run(2, 16, 2, t0, 1 << 30);
        pulse(2);
        goto(t0 + 45);

        chk("rd_all_seen",   q_rd.size() == 0,   $sformatf("got %0d pending, want 0", q_rd.size()));
        chk("wr_all_seen",   q_wr.size() == 0,   $sformatf("got %0d pending, want 0", q_wr.size()));
        chk("done_all_seen", q_done.size() == 0, $sformatf("got %0d pending, want 0", q_done.size()));
        chk("busy_all_seen", q_busy.size() == 0, $sformatf("got %0d pending, want 0", q_busy.size()));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
